// File: rtl/pc_seq_pkg.sv
// Shared types, default sizes and the RUN-state request decoder for the PC sequencer.
// The return stack is compiled in only when PC_SEQ_STACK_EN is defined.
package pc_seq_pkg;

    localparam int DEFAULT_ADDR_W      = 6;
    localparam int DEFAULT_STACK_DEPTH = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } pcSeqState_e;

    typedef enum logic [2:0] {
        ACT_NONE      = 3'd0,
        ACT_HOLD      = 3'd1,
        ACT_HALT      = 3'd2,
        ACT_JUMP      = 3'd3,
        ACT_CALL      = 3'd4,
        ACT_RET       = 3'd5,
        ACT_STACK_ERR = 3'd6
    } pcAct_e;

    // A refused call or return still wins priority, so it masks lower requests.
    function automatic pcAct_e decodeRun(
        input logic halt,
        input logic stall,
        input logic ret,
        input logic call,
        input logic jump,
        input logic branch,
        input logic cond,
        input logic full,
        input logic empty
    );
        pcAct_e act;
        if (halt) begin
            act = ACT_HALT;
        end else if (stall) begin
            act = ACT_HOLD;
        end else if (ret) begin
            act = empty ? ACT_STACK_ERR : ACT_RET;
        end else if (call) begin
            act = full ? ACT_STACK_ERR : ACT_CALL;
        end else if (jump || (branch && cond)) begin
            act = ACT_JUMP;
        end else begin
            act = ACT_NONE;
        end
        return act;
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; depth counts occupied entries, storage itself is not reset.
module return_stack #(
    parameter int ADDR_W      = 6,
    parameter int STACK_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           nReset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ADDR_W-1:0]              pushData,
    output logic [ADDR_W-1:0]              top,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           full,
    output logic                           empty
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_r [STACK_DEPTH];
    logic [CNT_W-1:0]  depth_r;
    logic [CNT_W-1:0]  depthDec_s;
    logic              doPush_s;
    logic              doPop_s;

    assign full       = (depth_r == CNT_W'(STACK_DEPTH));
    assign empty      = (depth_r == {CNT_W{1'b0}});
    assign doPush_s   = push && !full;
    assign doPop_s    = pop && !empty && !push;
    assign depthDec_s = depth_r - {{PTR_W{1'b0}}, 1'b1};
    assign top        = mem_r[depthDec_s[PTR_W-1:0]];
    assign depth      = depth_r;

    // Occupancy counter.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            depth_r <= {CNT_W{1'b0}};
        end else if (doPush_s) begin
            depth_r <= depth_r + {{PTR_W{1'b0}}, 1'b1};
        end else if (doPop_s) begin
            depth_r <= depthDec_s;
        end else begin
            depth_r <= depth_r;
        end
    end

    // Entry storage, written at the current fill level.
    always_ff @(posedge clk) begin
        if (doPush_s) begin
            mem_r[depth_r[PTR_W-1:0]] <= pushData;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC redirect sequencer: RUN/FLUSH/HALTED FSM steering ProgramCounter WriteEnable/AddrIn.
// Define PC_SEQ_STACK_EN to compile in the call/return stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic                           clk,
    input  logic                           nReset,
    input  logic [ADDR_W-1:0]              PcIn,
    input  logic                           Stall,
    input  logic                           Halt,
    input  logic                           JumpReq,
    input  logic [ADDR_W-1:0]              JumpAddr,
    input  logic                           BranchReq,
    input  logic                           BranchCond,
    input  logic                           CallReq,
    input  logic                           RetReq,
    output logic                           PcWriteEnable,
    output logic [ADDR_W-1:0]              PcAddrIn,
    output logic                           Flush,
    output logic                           StackErr,
    output logic [$clog2(STACK_DEPTH):0]   StackDepth
);

    localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

    pcSeqState_e       state_r;
    pcSeqState_e       nextState_s;
    pcAct_e            act_s;
    logic              callEn_s;
    logic              retEn_s;
    logic              stackFull_s;
    logic              stackEmpty_s;
    logic [ADDR_W-1:0] stackTop_s;
    logic              push_s;
    logic              pop_s;
    logic              stackErrSet_s;

`ifdef PC_SEQ_STACK_EN
    logic [ADDR_W-1:0] retAddr_s;
    logic              stackErr_r;

    assign callEn_s  = CallReq;
    assign retEn_s   = RetReq;
    assign retAddr_s = PcIn + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign StackErr  = stackErr_r;

    return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) uStack (
        .clk      (clk),
        .nReset   (nReset),
        .push     (push_s),
        .pop      (pop_s),
        .pushData (retAddr_s),
        .top      (stackTop_s),
        .depth    (StackDepth),
        .full     (stackFull_s),
        .empty    (stackEmpty_s)
    );

    // Sticky stack error; only reset clears it.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            stackErr_r <= 1'b0;
        end else if (stackErrSet_s) begin
            stackErr_r <= 1'b1;
        end else begin
            stackErr_r <= stackErr_r;
        end
    end
`else
    logic unusedStack_s;

    assign callEn_s      = 1'b0;
    assign retEn_s       = 1'b0;
    assign stackFull_s   = 1'b0;
    assign stackEmpty_s  = 1'b1;
    assign stackTop_s    = {ADDR_W{1'b0}};
    assign StackErr      = 1'b0;
    assign StackDepth    = {CNT_W{1'b0}};
    assign unusedStack_s = ^{CallReq, RetReq, push_s, pop_s, stackErrSet_s};
`endif

    assign act_s = decodeRun(Halt, Stall, retEn_s, callEn_s, JumpReq, BranchReq,
                             BranchCond, stackFull_s, stackEmpty_s);

    // State register.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_r <= RUN;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            RUN: begin
                case (act_s)
                    ACT_HALT:                   nextState_s = HALTED;
                    ACT_JUMP, ACT_CALL, ACT_RET: nextState_s = FLUSH;
                    default:                    nextState_s = RUN;
                endcase
            end
            FLUSH: begin
                if (Halt) begin
                    nextState_s = HALTED;
                end else begin
                    nextState_s = RUN;
                end
            end
            HALTED:  nextState_s = HALTED;
            default: nextState_s = RUN;
        endcase
    end

    // Output logic; reset gates the PC controls so they drop without waiting for a clock.
    always_comb begin
        PcWriteEnable = 1'b0;
        PcAddrIn      = {ADDR_W{1'b0}};
        Flush         = 1'b0;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        stackErrSet_s = 1'b0;
        if (!nReset) begin
            PcWriteEnable = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    case (act_s)
                        ACT_HALT, ACT_HOLD: begin
                            PcWriteEnable = 1'b1;
                            PcAddrIn      = PcIn;
                        end
                        ACT_JUMP: begin
                            PcWriteEnable = 1'b1;
                            PcAddrIn      = JumpAddr;
                        end
                        ACT_CALL: begin
                            PcWriteEnable = 1'b1;
                            PcAddrIn      = JumpAddr;
                            push_s        = 1'b1;
                        end
                        ACT_RET: begin
                            PcWriteEnable = 1'b1;
                            PcAddrIn      = stackTop_s;
                            pop_s         = 1'b1;
                        end
                        ACT_STACK_ERR: stackErrSet_s = 1'b1;
                        default:       PcWriteEnable = 1'b0;
                    endcase
                end
                FLUSH: begin
                    Flush = 1'b1;
                    if (Halt) begin
                        PcWriteEnable = 1'b1;
                        PcAddrIn      = PcIn;
                    end else begin
                        PcWriteEnable = 1'b0;
                    end
                end
                HALTED: begin
                    PcWriteEnable = 1'b1;
                    PcAddrIn      = PcIn;
                end
                default: PcWriteEnable = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver queues one expectation per cycle,
// a negedge monitor pops and compares. Stack scenarios follow PC_SEQ_STACK_EN.
module tb_pc_sequencer;

    logic       clk;
    logic       nReset;
    logic [5:0] PcIn;
    logic       Stall;
    logic       Halt;
    logic       JumpReq;
    logic [5:0] JumpAddr;
    logic       BranchReq;
    logic       BranchCond;
    logic       CallReq;
    logic       RetReq;
    logic       PcWriteEnable;
    logic [5:0] PcAddrIn;
    logic       Flush;
    logic       StackErr;
    logic [2:0] StackDepth;

    typedef struct packed {
        logic       we;
        logic [5:0] addr;
        logic       fl;
        logic [2:0] dep;
        logic       err;
    } exp_t;

    exp_t       expQ[$];
    string      nameQ[$];
    exp_t       monE;
    string      monN;
    int         nCmp;
    int         nBad;
    logic [2:0] expDep;
    logic       expErr;

    pc_sequencer #(.ADDR_W(6), .STACK_DEPTH(4)) dut (
        .clk           (clk),
        .nReset        (nReset),
        .PcIn          (PcIn),
        .Stall         (Stall),
        .Halt          (Halt),
        .JumpReq       (JumpReq),
        .JumpAddr      (JumpAddr),
        .BranchReq     (BranchReq),
        .BranchCond    (BranchCond),
        .CallReq       (CallReq),
        .RetReq        (RetReq),
        .PcWriteEnable (PcWriteEnable),
        .PcAddrIn      (PcAddrIn),
        .Flush         (Flush),
        .StackErr      (StackErr),
        .StackDepth    (StackDepth)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            monE = expQ.pop_front();
            monN = nameQ.pop_front();
            chk({monN, ".we"},    {7'd0, PcWriteEnable}, {7'd0, monE.we});
            chk({monN, ".addr"},  {2'd0, PcAddrIn},      {2'd0, monE.addr});
            chk({monN, ".flush"}, {7'd0, Flush},         {7'd0, monE.fl});
            chk({monN, ".depth"}, {5'd0, StackDepth},    {5'd0, monE.dep});
            chk({monN, ".err"},   {7'd0, StackErr},      {7'd0, monE.err});
        end
    end

    task automatic clr();
        Halt = 1'b0; Stall = 1'b0; JumpReq = 1'b0; BranchReq = 1'b0;
        BranchCond = 1'b0; CallReq = 1'b0; RetReq = 1'b0;
    endtask

    task automatic cyc(input logic we, input logic [5:0] addr, input logic fl, input string nm);
        exp_t e;
        e.we = we; e.addr = addr; e.fl = fl; e.dep = expDep; e.err = expErr;
        expQ.push_back(e);
        nameQ.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle reset pulse, 3 ns low; outputs must be zero while it is low.
    task automatic resetPulse(input string nm);
        #3;
        nReset = 1'b0;
        #1;
        chk({nm, ".we"},    {7'd0, PcWriteEnable}, 8'd0);
        chk({nm, ".addr"},  {2'd0, PcAddrIn},      8'd0);
        chk({nm, ".flush"}, {7'd0, Flush},         8'd0);
        chk({nm, ".depth"}, {5'd0, StackDepth},    8'd0);
        chk({nm, ".err"},   {7'd0, StackErr},      8'd0);
        expDep = 3'd0;
        expErr = 1'b0;
        #2;
        nReset = 1'b1;
        clr();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        nCmp = 0; nBad = 0; expDep = 3'd0; expErr = 1'b0;
        clk = 1'b0; nReset = 1'b0; clr();
        Stall = 1'b1; PcIn = 6'd9; JumpAddr = 6'd0;
        @(posedge clk);
        #1;
        cyc(1'b0, 6'd0, 1'b0, "reset_hold");
        nReset = 1'b1;
        clr();

        for (int p = 0; p < 6; p++) begin
            PcIn = 6'(p);
            cyc(1'b0, 6'd0, 1'b0, "idle");
        end

        PcIn = 6'd6; JumpReq = 1'b1; JumpAddr = 6'd26;
        cyc(1'b1, 6'd26, 1'b0, "jump");
        PcIn = 6'd26; JumpAddr = 6'd50;
        cyc(1'b0, 6'd0, 1'b1, "jump_flush_ignores_jump");
        clr(); PcIn = 6'd27;
        cyc(1'b0, 6'd0, 1'b0, "after_flush");

        PcIn = 6'd22; Stall = 1'b1; JumpReq = 1'b1; JumpAddr = 6'd40;
        cyc(1'b1, 6'd22, 1'b0, "stall_over_jump");
        clr();
        cyc(1'b0, 6'd0, 1'b0, "no_flush_after_stall");

        PcIn = 6'd23; BranchReq = 1'b1; BranchCond = 1'b0; JumpAddr = 6'd33;
        cyc(1'b0, 6'd0, 1'b0, "branch_not_taken");
        clr(); PcIn = 6'd24;
        cyc(1'b0, 6'd0, 1'b0, "branch_nt_no_flush");
        BranchReq = 1'b1; BranchCond = 1'b1;
        cyc(1'b1, 6'd33, 1'b0, "branch_taken");
        clr(); PcIn = 6'd33; Stall = 1'b1;
        cyc(1'b0, 6'd0, 1'b1, "branch_flush_ignores_stall");
        clr(); PcIn = 6'd34;
        cyc(1'b0, 6'd0, 1'b0, "after_branch_flush");

`ifdef PC_SEQ_STACK_EN
        PcIn = 6'd10; CallReq = 1'b1; JumpAddr = 6'd40;
        cyc(1'b1, 6'd40, 1'b0, "call");
        clr(); expDep = 3'd1; PcIn = 6'd40;
        cyc(1'b0, 6'd0, 1'b1, "call_flush");
        PcIn = 6'd41; RetReq = 1'b1; CallReq = 1'b1; JumpAddr = 6'd7;
        cyc(1'b1, 6'd11, 1'b0, "ret_over_call");
        clr(); expDep = 3'd0; PcIn = 6'd11;
        cyc(1'b0, 6'd0, 1'b1, "ret_flush");

        PcIn = 6'd63; CallReq = 1'b1; JumpAddr = 6'd5;
        cyc(1'b1, 6'd5, 1'b0, "call_at_63");
        clr(); expDep = 3'd1; PcIn = 6'd5;
        cyc(1'b0, 6'd0, 1'b1, "call_at_63_flush");
        PcIn = 6'd6; RetReq = 1'b1;
        cyc(1'b1, 6'd0, 1'b0, "ret_wraps_to_0");
        clr(); expDep = 3'd0; PcIn = 6'd0;
        cyc(1'b0, 6'd0, 1'b1, "ret_wrap_flush");

        PcIn = 6'd1; RetReq = 1'b1; JumpReq = 1'b1; JumpAddr = 6'd9;
        cyc(1'b0, 6'd0, 1'b0, "ret_empty_no_redirect");
        clr(); expErr = 1'b1; PcIn = 6'd2;
        cyc(1'b0, 6'd0, 1'b0, "ret_empty_err_set");
        cyc(1'b0, 6'd0, 1'b0, "err_sticky");
        resetPulse("reset_clears_err");
        PcIn = 6'd3;
        cyc(1'b0, 6'd0, 1'b0, "err_cleared");

        for (int i = 0; i < 4; i++) begin
            PcIn = 6'(i + 1); CallReq = 1'b1; JumpAddr = 6'(20 + i);
            cyc(1'b1, 6'(20 + i), 1'b0, "call_n");
            clr(); expDep = 3'(i + 1); PcIn = 6'(20 + i);
            cyc(1'b0, 6'd0, 1'b1, "call_n_flush");
        end
        PcIn = 6'd8; CallReq = 1'b1; JumpAddr = 6'd50;
        cyc(1'b0, 6'd0, 1'b0, "call_overflow_no_redirect");
        clr(); expErr = 1'b1; PcIn = 6'd9;
        cyc(1'b0, 6'd0, 1'b0, "overflow_err_no_flush");
        PcIn = 6'd10; RetReq = 1'b1;
        cyc(1'b1, 6'd5, 1'b0, "ret_after_overflow");
        clr(); expDep = 3'd3; PcIn = 6'd5;
        cyc(1'b0, 6'd0, 1'b1, "ret_after_overflow_flush");
`else
        PcIn = 6'd10; CallReq = 1'b1; RetReq = 1'b1; JumpAddr = 6'd40;
        cyc(1'b0, 6'd0, 1'b0, "call_ret_ignored");
        clr(); PcIn = 6'd11;
        cyc(1'b0, 6'd0, 1'b0, "call_ret_ignored_no_flush");
        PcIn = 6'd12; CallReq = 1'b1; JumpReq = 1'b1; JumpAddr = 6'd44;
        cyc(1'b1, 6'd44, 1'b0, "jump_beside_ignored_call");
        clr(); PcIn = 6'd44;
        cyc(1'b0, 6'd0, 1'b1, "jump_beside_call_flush");
`endif

        PcIn = 6'd30; JumpReq = 1'b1; JumpAddr = 6'd45;
        cyc(1'b1, 6'd45, 1'b0, "jump_before_halt");
        clr(); Halt = 1'b1; PcIn = 6'd45;
        cyc(1'b1, 6'd45, 1'b1, "halt_in_flush");
        clr(); JumpReq = 1'b1; JumpAddr = 6'd12; PcIn = 6'd46;
        cyc(1'b1, 6'd46, 1'b0, "halted_hold");
        PcIn = 6'd47; RetReq = 1'b1;
        cyc(1'b1, 6'd47, 1'b0, "halted_ignores_inputs");
        resetPulse("reset_from_halted");
        PcIn = 6'd0;
        cyc(1'b0, 6'd0, 1'b0, "run_after_reset");
        PcIn = 6'd1; JumpReq = 1'b1; JumpAddr = 6'd17;
        cyc(1'b1, 6'd17, 1'b0, "jump_after_reset");
        clr(); PcIn = 6'd17;
        cyc(1'b0, 6'd0, 1'b1, "flush_after_reset");

        @(negedge clk);
        #1;
        chk("queue_drained", 8'(expQ.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
